// File: rtl/fm_feeder.sv
// fm_feeder: streams a column-major int8 feature map from BRAM_FM64 into the
// systolic array, one tile of LANES rows at a time, with a per-lane diagonal skew.
module fm_feeder #(
  parameter int LANES = 8,
  parameter int SKEW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        M,
  input  logic [15:0]        N,
  input  logic               feed_start,
  input  logic               array_ready,
  output logic               feed_finish,
  output logic [15:0]        BRAM_FM64_raddr,
  input  logic [LANES*8-1:0] BRAM_FM64_rddata,
  output logic [LANES*8-1:0] fm_out,
  output logic [LANES-1:0]   fm_valid,
  output logic [LANES-1:0]   fm_last
);
  localparam int LANE_SH   = $clog2(LANES);
  localparam int DRAIN_CYC = (LANES - 1) * SKEW + 2;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    COM    = 5'b00010,
    READ   = 5'b00100,
    DRAIN  = 5'b01000,
    FINISH = 5'b10000
  } state_t;

  state_t             state_r, state_s;
  logic [15:0]        m_r, n_r, tiles_r, tile_r, col_r, raddr_r;
  logic [16:0]        tile_base_r;
  logic [7:0]         drain_cnt_r;
  logic               finish_r;
  logic               stall_s, col_last_s, addr_last_s;
  logic [LANES-1:0]   mask_s;
  logic [LANES*8-1:0] word_s;

  logic               p1_vld_r, p1_last_r, hold_vld_r;
  logic [LANES-1:0]   p1_mask_r;
  logic [LANES*8-1:0] hold_r;
  logic [LANES*8-1:0] s0_data_r;
  logic [LANES-1:0]   s0_vld_r, s0_last_r;

  // Stall detect, scan-position flags, capture source and per-lane row mask.
  always_comb begin
    stall_s     = ((state_r == READ) || (state_r == DRAIN)) && !array_ready;
    col_last_s  = (col_r == n_r - 16'd1);
    addr_last_s = col_last_s && (tile_r == tiles_r - 16'd1);
    word_s      = hold_vld_r ? hold_r : BRAM_FM64_rddata;
    for (int i = 0; i < LANES; i++) begin
      mask_s[i] = (tile_base_r + 17'(i)) < {1'b0, m_r};
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (feed_start) state_s = COM; else state_s = IDLE;
      COM:     if ((M != 16'd0) && (N != 16'd0)) state_s = READ; else state_s = FINISH;
      READ:    if (array_ready && addr_last_s) state_s = DRAIN; else state_s = READ;
      DRAIN:   if (array_ready && (drain_cnt_r == 8'(DRAIN_CYC - 1))) state_s = FINISH;
               else state_s = DRAIN;
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Scan counters; raddr = n*T + t is kept by adding T per column.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r         <= 16'd0;
      n_r         <= 16'd0;
      tiles_r     <= 16'd0;
      tile_r      <= 16'd0;
      col_r       <= 16'd0;
      raddr_r     <= 16'd0;
      tile_base_r <= 17'd0;
      drain_cnt_r <= 8'd0;
      finish_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (feed_start) finish_r <= 1'b0;
        COM: begin
          m_r         <= M;
          n_r         <= N;
          tiles_r     <= ((M - 16'd1) >> LANE_SH) + 16'd1;
          tile_r      <= 16'd0;
          col_r       <= 16'd0;
          raddr_r     <= 16'd0;
          tile_base_r <= 17'd0;
          drain_cnt_r <= 8'd0;
        end
        READ: if (array_ready) begin
          if (col_last_s) begin
            col_r       <= 16'd0;
            tile_r      <= tile_r + 16'd1;
            raddr_r     <= tile_r + 16'd1;
            tile_base_r <= tile_base_r + 17'(LANES);
          end else begin
            col_r   <= col_r + 16'd1;
            raddr_r <= raddr_r + tiles_r;
          end
        end
        DRAIN:   if (array_ready) drain_cnt_r <= drain_cnt_r + 8'd1;
        FINISH:  finish_r <= 1'b1;
        default: ;
      endcase
    end
  end

  // Address tags and stage-0 capture. The BRAM keeps reading during a stall, so
  // the word belonging to the in-flight address is parked in hold_r on the
  // first stalled cycle and used in place of rddata when the array resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld_r   <= 1'b0;
      p1_last_r  <= 1'b0;
      p1_mask_r  <= '0;
      hold_vld_r <= 1'b0;
      hold_r     <= '0;
      s0_data_r  <= '0;
      s0_vld_r   <= '0;
      s0_last_r  <= '0;
    end else if (!stall_s) begin
      p1_vld_r   <= (state_r == READ);
      p1_last_r  <= col_last_s;
      p1_mask_r  <= mask_s;
      hold_vld_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s0_vld_r[i]        <= p1_vld_r & p1_mask_r[i];
        s0_last_r[i]       <= p1_vld_r & p1_mask_r[i] & p1_last_r;
        s0_data_r[i*8 +: 8] <= (p1_vld_r & p1_mask_r[i]) ? word_s[i*8 +: 8] : 8'd0;
      end
    end else if (!hold_vld_r) begin
      hold_r     <= BRAM_FM64_rddata;
      hold_vld_r <= 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int DEPTH = g * SKEW;
    logic [9:0] head_s;
    assign head_s = {s0_last_r[g], s0_vld_r[g], s0_data_r[g*8 +: 8]};
    if (DEPTH == 0) begin : g_direct
      assign {fm_last[g], fm_valid[g], fm_out[g*8 +: 8]} = head_s;
    end else begin : g_skew
      logic [9:0] sr_r [DEPTH];
      // Per-lane delay line, frozen with the rest of the datapath on stall.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < DEPTH; j++) sr_r[j] <= 10'd0;
        end else if (!stall_s) begin
          sr_r[0] <= head_s;
          for (int j = 1; j < DEPTH; j++) sr_r[j] <= sr_r[j-1];
        end
      end
      assign {fm_last[g], fm_valid[g], fm_out[g*8 +: 8]} = sr_r[DEPTH-1];
    end
  end

  assign feed_finish     = finish_r;
  assign BRAM_FM64_raddr = raddr_r;
endmodule

// File: tb/tb_fm_feeder.sv
// Table-driven bench for fm_feeder: BRAM model, per-lane output scoreboard built
// from the storage layout, plus hand sequences for address order, stall and reset.
module tb_fm_feeder;
  logic        clk = 1'b0;
  logic        rst, feed_start, array_ready, feed_finish;
  logic [15:0] M, N, raddr;
  logic [63:0] rddata, fm_out;
  logic [7:0]  fm_valid, fm_last;

  int tests = 0;
  int fails = 0;
  bit bubble_bad;
  int addr_q[$];
  logic [8:0] lane_q [8][$];

  typedef struct {
    logic [15:0] m;
    logic [15:0] n;
    bit          stall;
    int          exp_lat;
    int          exp_nvalid;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  fm_feeder dut (
    .clk(clk), .rst(rst), .M(M), .N(N), .feed_start(feed_start),
    .array_ready(array_ready), .feed_finish(feed_finish),
    .BRAM_FM64_raddr(raddr), .BRAM_FM64_rddata(rddata),
    .fm_out(fm_out), .fm_valid(fm_valid), .fm_last(fm_last)
  );

  function automatic logic [63:0] bram_word(input logic [15:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = {a[4:0], 3'(i)};
    return w;
  endfunction

  // Synchronous-read BRAM: data one cycle after the address.
  always @(posedge clk) rddata <= bram_word(raddr);

  // Record accepted lane elements and flag any non-zero bubble.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (fm_valid[i] && array_ready) lane_q[i].push_back({fm_last[i], fm_out[i*8 +: 8]});
      if (!fm_valid[i] && ((fm_out[i*8 +: 8] != 8'd0) || fm_last[i])) bubble_bad = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input bit mid);
    int lat, tt, nv;
    bit done;
    logic [63:0] w;
    logic [8:0] exp_q[$];
    for (int i = 0; i < 8; i++) lane_q[i].delete();
    addr_q.delete();
    bubble_bad  = 1'b0;
    M           = v.m;
    N           = v.n;
    array_ready = 1'b1;
    feed_start  = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 3000) begin
      step();
      lat++;
      feed_start  = mid && (lat == 3);
      array_ready = v.stall ? ((lat % 4 == 0) || (lat % 4 == 3)) : 1'b1;
      if (lat == 1) check("finish_clear", 64'(feed_finish), 64'd0);
      if (lat >= 2 && addr_q.size() < 16) addr_q.push_back(int'(raddr));
      if (feed_finish) done = 1'b1;
    end
    array_ready = 1'b1;
    feed_start  = 1'b0;
    check($sformatf("finish_seen m=%0d n=%0d", v.m, v.n), 64'(done), 64'd1);
    if (v.exp_lat >= 0) check($sformatf("latency m=%0d n=%0d", v.m, v.n), 64'(lat), 64'(v.exp_lat));
    tt = (v.m == 16'd0) ? 0 : ((int'(v.m) - 1) / 8 + 1);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      for (int t = 0; t < tt; t++)
        for (int n = 0; n < int'(v.n); n++)
          if (8 * t + i < int'(v.m)) begin
            w = bram_word(16'(n * tt + t));
            exp_q.push_back({(n == int'(v.n) - 1), w[i*8 +: 8]});
          end
      check($sformatf("lane%0d_len m=%0d n=%0d", i, v.m, v.n), 64'(lane_q[i].size()), 64'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++)
        check($sformatf("lane%0d_elem%0d m=%0d n=%0d", i, j, v.m, v.n),
              64'((j < lane_q[i].size()) ? lane_q[i][j] : 9'h1ff), 64'(exp_q[j]));
      nv += lane_q[i].size();
    end
    check($sformatf("nvalid m=%0d n=%0d", v.m, v.n), 64'(nv), 64'(v.exp_nvalid));
    check($sformatf("bubble m=%0d n=%0d", v.m, v.n), 64'(bubble_bad), 64'd0);
  endtask

  initial begin
    int exp_a0[3];
    int exp_a1[4];
    bit vld_seen;
    vecs[0] = '{m: 16'd8,  n: 16'd3, stall: 1'b0, exp_lat: 15, exp_nvalid: 24};
    vecs[1] = '{m: 16'd12, n: 16'd2, stall: 1'b0, exp_lat: 16, exp_nvalid: 24};
    vecs[2] = '{m: 16'd0,  n: 16'd5, stall: 1'b0, exp_lat: 3,  exp_nvalid: 0};
    vecs[3] = '{m: 16'd7,  n: 16'd0, stall: 1'b0, exp_lat: 3,  exp_nvalid: 0};
    vecs[4] = '{m: 16'd16, n: 16'd4, stall: 1'b0, exp_lat: 20, exp_nvalid: 64};
    vecs[5] = '{m: 16'd16, n: 16'd4, stall: 1'b1, exp_lat: -1, exp_nvalid: 64};
    vecs[6] = '{m: 16'd1,  n: 16'd1, stall: 1'b0, exp_lat: 13, exp_nvalid: 1};
    vecs[7] = '{m: 16'd20, n: 16'd3, stall: 1'b0, exp_lat: 21, exp_nvalid: 60};
    vecs[8] = '{m: 16'd8,  n: 16'd8, stall: 1'b0, exp_lat: 20, exp_nvalid: 64};
    exp_a0 = '{0, 1, 2};
    exp_a1 = '{0, 2, 1, 3};

    rst = 1'b1; M = 16'd0; N = 16'd0; feed_start = 1'b0; array_ready = 1'b1;
    repeat (3) step();
    check("rst_raddr", 64'(raddr), 64'd0);
    check("rst_fm_out", fm_out, 64'd0);
    check("rst_fm_valid", 64'(fm_valid), 64'd0);
    check("rst_fm_last", 64'(fm_last), 64'd0);
    check("rst_finish", 64'(feed_finish), 64'd0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 9; k++) run(vecs[k], 1'b0);

    run(vecs[0], 1'b0);
    for (int j = 0; j < 3; j++)
      check($sformatf("addr_m8n3_%0d", j), 64'((j < addr_q.size()) ? addr_q[j] : -1), 64'(exp_a0[j]));
    run(vecs[1], 1'b1);
    for (int j = 0; j < 4; j++)
      check($sformatf("addr_m12n2_mid_%0d", j), 64'((j < addr_q.size()) ? addr_q[j] : -1), 64'(exp_a1[j]));

    // Reset asserted in the fourth READ cycle of an 8x8 run.
    M = 16'd8; N = 16'd8; feed_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      feed_start = 1'b0;
    end
    rst = 1'b1;
    step();
    check("midrst_fm_out", fm_out, 64'd0);
    check("midrst_fm_valid", 64'(fm_valid), 64'd0);
    check("midrst_fm_last", 64'(fm_last), 64'd0);
    check("midrst_finish", 64'(feed_finish), 64'd0);
    check("midrst_raddr", 64'(raddr), 64'd0);
    rst = 1'b0;
    vld_seen = 1'b0;
    repeat (20) begin
      step();
      if (fm_valid != 8'd0) vld_seen = 1'b1;
    end
    check("midrst_quiet", 64'(vld_seen), 64'd0);
    run(vecs[8], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
